// File: rtl/cory_packn.sv
// cory_packn: M-channel valid/ready packer.
// Each input channel is captured into its own hold register. When every hold is
// full, the lanes are concatenated (channel 0 at the LSBs) and pushed into a
// D-entry output FIFO, so the input ready never depends on the output ready.
//
// Handshake rules: a transfer happens on a rising clk edge where valid and ready
// are both high. o_a_r depends only on registered state and reset_n (plus
// i_flush when flush is enabled). o_z_v/o_z_d hold steady while o_z_v & ~i_z_r.
//
// Optional build macro: CORY_PACKN_FLUSH_EN adds i_flush (emit a partial word
// with empty lanes zero-filled) and o_z_m (lane-valid mask of the head word).
module cory_packn #(
  parameter  int N = 16,
  parameter  int M = 2,
  parameter  int D = 2,
  localparam int Z = M * N
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [M-1:0] i_a_v,
  input  logic [Z-1:0] i_a_d,
  output logic [M-1:0] o_a_r,
  output logic         o_z_v,
  output logic [Z-1:0] o_z_d,
  input  logic         i_z_r
`ifdef CORY_PACKN_FLUSH_EN
  ,
  input  logic         i_flush,
  output logic [M-1:0] o_z_m
`endif
);

  // Pointer width is at least one bit so D=1 still yields legal vectors.
  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);

  // Gather state
  logic [M-1:0]  r_h_v;
  logic [Z-1:0]  r_hold;

  // Output FIFO state
  logic [Z-1:0]  r_mem [0:D-1];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;
  logic [Z-1:0]  r_last_d;

  // Combinational control
  logic          w_not_full;
  logic          w_fire;
  logic          w_pop;
  logic [M-1:0]  w_hs;
  logic [Z-1:0]  w_push_d;
  logic [PW-1:0] w_wr_ptr_nxt;
  logic [PW-1:0] w_rd_ptr_nxt;

`ifdef CORY_PACKN_FLUSH_EN
  logic [M-1:0]  r_mem_m [0:D-1];
  logic [M-1:0]  r_last_m;
`endif

  assign w_not_full = (r_cnt < CW'(D));
  assign w_pop      = o_z_v & i_z_r;

`ifdef CORY_PACKN_FLUSH_EN
  // A flush emits whatever lanes are held; with nothing held it is ignored.
  assign w_fire = ((&r_h_v) | (i_flush & (|r_h_v))) & w_not_full;
`else
  assign w_fire = (&r_h_v) & w_not_full;
`endif

  // A lane can accept when empty, or when its content leaves this cycle.
  assign o_a_r = {M{reset_n}} & (~r_h_v | {M{w_fire}});
  assign w_hs  = i_a_v & o_a_r;

  // Assemble the word to push; empty lanes only exist on a flush.
  always_comb begin
    w_push_d = r_hold;
`ifdef CORY_PACKN_FLUSH_EN
    for (int k = 0; k < M; k++) begin
      if (!r_h_v[k]) w_push_d[k*N +: N] = '0;
    end
`endif
  end

  // Pointer increments wrap at D, which need not be a power of two.
  always_comb begin
    w_wr_ptr_nxt = (r_wr_ptr == PW'(D - 1)) ? '0 : r_wr_ptr + 1'b1;
    w_rd_ptr_nxt = (r_rd_ptr == PW'(D - 1)) ? '0 : r_rd_ptr + 1'b1;
  end

  // Per-lane hold registers: capture on handshake, release on fire.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h_v  <= '0;
      r_hold <= '0;
    end else begin
      for (int k = 0; k < M; k++) begin
        if (w_hs[k]) begin
          r_hold[k*N +: N] <= i_a_d[k*N +: N];
          r_h_v[k]         <= 1'b1;
        end else if (w_fire) begin
          r_h_v[k]         <= 1'b0;
        end
      end
    end
  end

  // FIFO storage; contents are only visible through the count, so no reset.
  always_ff @(posedge clk) begin
    if (w_fire) begin
      r_mem[r_wr_ptr] <= w_push_d;
`ifdef CORY_PACKN_FLUSH_EN
      r_mem_m[r_wr_ptr] <= r_h_v;
`endif
    end
  end

  // FIFO pointers, occupancy and the last-popped word shown while empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_last_d <= '0;
`ifdef CORY_PACKN_FLUSH_EN
      r_last_m <= '0;
`endif
    end else begin
      if (w_fire) r_wr_ptr <= w_wr_ptr_nxt;
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_nxt;
        r_last_d <= r_mem[r_rd_ptr];
`ifdef CORY_PACKN_FLUSH_EN
        r_last_m <= r_mem_m[r_rd_ptr];
`endif
      end
      case ({w_fire, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_z_v = (r_cnt != '0);
  assign o_z_d = o_z_v ? r_mem[r_rd_ptr] : r_last_d;
`ifdef CORY_PACKN_FLUSH_EN
  assign o_z_m = o_z_v ? r_mem_m[r_rd_ptr] : r_last_m;
`endif

endmodule
